jtag_scan_engine: RTL and testbench
===================================

# jtag_scan_engine

Parametrised JTAG scan sequencer that drives TMS/TDI and samples TDO to perform one complete IR+DR scan, a DR-only scan, or a TAP reset per request. It generalises the fixed TMS walk patterns and fixed instruction and vector widths to run-time widths bounded by parameters. It tracks all 16 IEEE 1149.1 TAP states internally. It sits between the JTAG master driver/BFM and the TAP pins, advancing one TCK step per `clk` cycle.

## Interface
- `MAX_IR_WIDTH`, default 5: maximum instruction length.
- `MAX_DR_WIDTH`, default 32: maximum data-register length.
- `IRW = $clog2(MAX_IR_WIDTH+1)`, `DRW = $clog2(MAX_DR_WIDTH+1)`: derived width localparams.

Ports:
- `clk`  in  1  clock; one cycle equals one TCK step.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request, sampled while idle.
- `skipIr`  in  1  latched at start; 1 = DR-only scan.
- `resetTap`  in  1  TAP reset request, sampled while idle.
- `irWidth`  in  IRW  instruction length, latched at start.
- `drWidth`  in  DRW  data length, latched at start.
- `irData`  in  MAX_IR_WIDTH  instruction, shifted LSB first.
- `drData`  in  MAX_DR_WIDTH  test vector, shifted LSB first.
- `tdo`  in  1  TAP serial output.
- `tms`  out  1  registered TMS.
- `tdi`  out  1  registered TDI.
- `tapState`  out  4  current TAP state. Encoding: 0 reset, 1 idle, 2 drScan, 3 irScan, 4 captureIr, 5 shiftIr, 6 exit1Ir, 7 pauseIr, 8 exit2Ir, 9 updateIr, 10 captureDr, 11 shiftDr, 12 exit1Dr, 13 pauseDr, 14 exit2Dr, 15 updateDr.
- `capturedDr`  out  MAX_DR_WIDTH  TDO bits captured during the last DR scan; first bit at bit 0.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Next-state logic implements all 16 TAP transitions. The pause states are never entered by this engine but must be modelled. On every clock edge: `tapState <= next(tapState, tms)`.
- Engine FSM states: IDLE, TO_IDLE, WALK_IR, SHIFT_IR, WALK_DR, SHIFT_DR, EXIT, TAP_RST.
- While IDLE, `tms` holds the current TAP state: `tms` = 1 if `tapState` = 0, and `tms` = 0 if `tapState` = 1.
- `start` accepted while IDLE:
  - Rejected if `drWidth` = 0 or `drWidth` > MAX_DR_WIDTH.
  - Rejected if `skipIr` = 0 and (`irWidth` = 0 or `irWidth` > MAX_IR_WIDTH).
  - On rejection: `err` pulses for one cycle, with no TMS activity.
  - On acceptance: all operands are latched.
- TMS sequence for an accepted scan:
  - If `tapState` = 0: one `tms` = 0 step to idle.
  - IR walk (skipped if `skipIr`): 1,1,0,0 to shiftIr.
  - IR shift: `irWidth` steps; `tms` = 1 on the last step only.
  - IR exit: 1,1 to updateIr, then drScan.
  - DR walk: 0,0 to shiftDr. If `skipIr`, the DR walk from idle is 1,0,0 instead.
  - DR shift: `drWidth` steps; `tms` = 1 on the last step only.
  - Exit: 1,0 to updateDr, then idle.
- `tdi` equals the next bit (LSB first) on shiftIr/shiftDr steps and 0 on all other steps.
- Capture: at each edge where `tapState` = 11, `tdo` is sampled into bit k of the capture shift register, where k counts 0..drWidth-1.
- `capturedDr` updates when the scan reaches idle. Bits at drWidth and above read 0.
- `resetTap` while IDLE drives `tms` = 1 for 5 steps, ending in state 0, then `done`.
- Priority: `resetTap` wins over a simultaneous `start`. Both are ignored while `busy`.

## Timing
- Reset values: `tms` = 1, `tdi` = 0, `tapState` = 0, `busy` = 0, `done` = 0, `err` = 0, `capturedDr` = 0, engine FSM = IDLE.
- Request sampled at edge t: `busy` = 1 and the first driven `tms` appear in cycle t+1.
- Scan length in steps (add 1 if starting from `tapState` = 0):
  - full scan: irWidth + drWidth + 10
  - DR-only scan: drWidth + 5
  - reset: 5
- `done` is asserted in the first cycle with `tapState` = 1 (or 0 after a reset request). `busy` falls in that same cycle.
- `err` is asserted in cycle t+1. `busy` stays 0.
- A synchronous `reset` mid-operation aborts the operation: all outputs return to their reset values in the next cycle, and no `done` is produced.

## Test plan
- Reset, then `start` with irWidth=5, irData=5'b00110, drWidth=8, drData=8'hA5, and a TDO model returning 8'h3C LSB first:
  - tms = 0, 1,1,0,0, 0,0,0,0,1, 1,1,0,0, 0×7,1, 1,0 (24 steps).
  - TDI carries the IR and DR bits only during the shift steps.
  - `capturedDr` = 8'h3C, one `done` pulse, `tapState` ends at 1.
- From idle, `skipIr`=1, drWidth=32, drData=32'hDEADBEEF → 37 steps; tms = 1,0,0, 0×31,1, 1,0; TDI bits = drData LSB first.
- From idle, `resetTap` → 5 cycles of `tms`=1, `tapState`=0, `done`. A subsequent `start` adds a leading `tms`=0 step.
- irWidth=6 with MAX_IR_WIDTH=5 → `err` pulse, `busy`=0, `tms` unchanged. drWidth=0 → `err`.
- `start` pulsed while `busy` → ignored, scan length unchanged. `start` and `resetTap` in the same cycle → reset sequence only.
- `reset` asserted during the 4th shiftDr step → next cycle `tapState`=0, `tms`=1, `busy`=0, `capturedDr`=0, no `done`.

Source files
------------

// File: rtl/jtag_scan_engine.sv
// JTAG scan sequencer: walks the TAP through IR+DR scans, DR-only scans or a TAP reset,
// one TCK step per clk cycle, with run-time instruction and data lengths.
module jtag_scan_engine #(
   parameter  int MAX_IR_WIDTH = 5,
   parameter  int MAX_DR_WIDTH = 32,
   localparam int IRW = $clog2(MAX_IR_WIDTH + 1),
   localparam int DRW = $clog2(MAX_DR_WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    skipIr,
   input  logic                    resetTap,
   input  logic [IRW-1:0]          irWidth,
   input  logic [DRW-1:0]          drWidth,
   input  logic [MAX_IR_WIDTH-1:0] irData,
   input  logic [MAX_DR_WIDTH-1:0] drData,
   input  logic                    tdo,
   output logic                    tms,
   output logic                    tdi,
   output logic [3:0]              tapState,
   output logic [MAX_DR_WIDTH-1:0] capturedDr,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int CW = (DRW > IRW) ? ((DRW > 3) ? DRW : 3) : ((IRW > 3) ? IRW : 3);

   typedef enum logic [3:0] {
      TAP_RESET, TAP_IDLE, TAP_DR_SCAN, TAP_IR_SCAN,
      TAP_CAPTURE_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR,
      TAP_EXIT2_IR, TAP_UPDATE_IR, TAP_CAPTURE_DR, TAP_SHIFT_DR,
      TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPDATE_DR
   } tap_t;

   typedef enum logic [2:0] {
      ENG_IDLE, ENG_TO_IDLE, ENG_WALK_IR, ENG_SHIFT_IR,
      ENG_WALK_DR, ENG_SHIFT_DR, ENG_EXIT, ENG_TAP_RST
   } eng_t;

   tap_t                    tap_state_reg;
   tap_t                    tap_next;
   eng_t                    eng_reg;
   logic                    tms_reg;
   logic                    tdi_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    err_reg;
   logic                    skip_reg;
   logic [CW-1:0]           cnt_reg;
   logic [CW-1:0]           ir_last_reg;
   logic [CW-1:0]           dr_last_reg;
   logic [MAX_IR_WIDTH-1:0] ir_sh_reg;
   logic [MAX_DR_WIDTH-1:0] dr_sh_reg;
   logic [MAX_DR_WIDTH-1:0] cap_reg;
   logic [MAX_DR_WIDTH-1:0] captured_reg;
   logic [MAX_DR_WIDTH-1:0] cap_hit;
   logic                    dr_bad;
   logic                    ir_bad;

   always_comb begin
      tap_next = tap_state_reg;
      case (tap_state_reg)
         TAP_RESET:      tap_next = tms_reg ? TAP_RESET     : TAP_IDLE;
         TAP_IDLE:       tap_next = tms_reg ? TAP_DR_SCAN   : TAP_IDLE;
         TAP_DR_SCAN:    tap_next = tms_reg ? TAP_IR_SCAN   : TAP_CAPTURE_DR;
         TAP_IR_SCAN:    tap_next = tms_reg ? TAP_RESET     : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: tap_next = tms_reg ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   tap_next = tms_reg ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   tap_next = tms_reg ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   tap_next = tms_reg ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   tap_next = tms_reg ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         TAP_UPDATE_IR:  tap_next = tms_reg ? TAP_DR_SCAN   : TAP_IDLE;
         TAP_CAPTURE_DR: tap_next = tms_reg ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   tap_next = tms_reg ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   tap_next = tms_reg ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   tap_next = tms_reg ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   tap_next = tms_reg ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  tap_next = tms_reg ? TAP_DR_SCAN   : TAP_IDLE;
         default:        tap_next = TAP_RESET;
      endcase
   end

   // One-hot select of the capture bit addressed by the shift counter.
   for (genvar gi = 0; gi < MAX_DR_WIDTH; gi++) begin : g_cap_hit
      assign cap_hit[gi] = (cnt_reg == CW'(gi));
   end

   assign dr_bad = (drWidth == '0) || (drWidth > DRW'(MAX_DR_WIDTH));
   assign ir_bad = !skipIr && ((irWidth == '0) || (irWidth > IRW'(MAX_IR_WIDTH)));

   always_ff @(posedge clk) begin
      if (reset) begin
         tap_state_reg <= TAP_RESET;
         eng_reg       <= ENG_IDLE;
         tms_reg       <= 1'b1;
         tdi_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         skip_reg      <= 1'b0;
         cnt_reg       <= '0;
         ir_last_reg   <= '0;
         dr_last_reg   <= '0;
         ir_sh_reg     <= '0;
         dr_sh_reg     <= '0;
         cap_reg       <= '0;
         captured_reg  <= '0;
      end else begin
         tap_state_reg <= tap_next;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         tdi_reg       <= 1'b0;
         case (eng_reg)
            ENG_IDLE: begin
               // Hold the TAP where it is: TMS high parks in reset, low parks in idle.
               tms_reg <= (tap_next != TAP_IDLE);
               if (resetTap) begin
                  eng_reg  <= ENG_TAP_RST;
                  cnt_reg  <= '0;
                  tms_reg  <= 1'b1;
                  busy_reg <= 1'b1;
               end else if (start) begin
                  if (dr_bad || ir_bad) begin
                     err_reg <= 1'b1;
                  end else begin
                     busy_reg    <= 1'b1;
                     skip_reg    <= skipIr;
                     ir_last_reg <= CW'(irWidth) - CW'(1);
                     dr_last_reg <= CW'(drWidth) - CW'(1);
                     ir_sh_reg   <= irData;
                     dr_sh_reg   <= drData;
                     cap_reg     <= '0;
                     cnt_reg     <= '0;
                     if (tap_state_reg == TAP_RESET) begin
                        eng_reg <= ENG_TO_IDLE;
                        tms_reg <= 1'b0;
                     end else begin
                        eng_reg <= skipIr ? ENG_WALK_DR : ENG_WALK_IR;
                        tms_reg <= 1'b1;
                     end
                  end
               end
            end
            ENG_TO_IDLE: begin
               eng_reg <= skip_reg ? ENG_WALK_DR : ENG_WALK_IR;
               tms_reg <= 1'b1;
            end
            ENG_WALK_IR: begin
               if (tap_next == TAP_SHIFT_IR) begin
                  eng_reg   <= ENG_SHIFT_IR;
                  cnt_reg   <= '0;
                  tms_reg   <= (ir_last_reg == '0);
                  tdi_reg   <= ir_sh_reg[0];
                  ir_sh_reg <= ir_sh_reg >> 1;
               end else begin
                  tms_reg <= (tap_next == TAP_DR_SCAN);
               end
            end
            ENG_SHIFT_IR: begin
               if (cnt_reg == ir_last_reg) begin
                  eng_reg <= ENG_WALK_DR;
                  tms_reg <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
                  tms_reg   <= ((cnt_reg + CW'(1)) == ir_last_reg);
                  tdi_reg   <= ir_sh_reg[0];
                  ir_sh_reg <= ir_sh_reg >> 1;
               end
            end
            ENG_WALK_DR: begin
               // Covers both exit1Ir->updateIr->drScan and the short walk from idle.
               if (tap_next == TAP_SHIFT_DR) begin
                  eng_reg   <= ENG_SHIFT_DR;
                  cnt_reg   <= '0;
                  tms_reg   <= (dr_last_reg == '0);
                  tdi_reg   <= dr_sh_reg[0];
                  dr_sh_reg <= dr_sh_reg >> 1;
               end else begin
                  tms_reg <= (tap_next == TAP_UPDATE_IR);
               end
            end
            ENG_SHIFT_DR: begin
               cap_reg <= (cap_reg & ~cap_hit) | ({MAX_DR_WIDTH{tdo}} & cap_hit);
               if (cnt_reg == dr_last_reg) begin
                  eng_reg <= ENG_EXIT;
                  tms_reg <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
                  tms_reg   <= ((cnt_reg + CW'(1)) == dr_last_reg);
                  tdi_reg   <= dr_sh_reg[0];
                  dr_sh_reg <= dr_sh_reg >> 1;
               end
            end
            ENG_EXIT: begin
               tms_reg <= 1'b0;
               if (tap_next == TAP_IDLE) begin
                  eng_reg      <= ENG_IDLE;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
                  captured_reg <= cap_reg;
               end
            end
            ENG_TAP_RST: begin
               tms_reg <= 1'b1;
               if (cnt_reg == CW'(4)) begin
                  eng_reg  <= ENG_IDLE;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: eng_reg <= ENG_IDLE;
         endcase
      end
   end

   assign tms        = tms_reg;
   assign tdi        = tdi_reg;
   assign tapState   = tap_state_reg;
   assign capturedDr = captured_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_jtag_scan_engine.sv
// Bench for jtag_scan_engine: builds expected TMS/TDI step lists from the scan rules and
// follows the TAP with a transition table, comparing every step.
module tb_jtag_scan_engine;

   localparam int MAX_IR = 5;
   localparam int MAX_DR = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              skipIr;
   logic              resetTap;
   logic [2:0]        irWidth;
   logic [5:0]        drWidth;
   logic [MAX_IR-1:0] irData;
   logic [MAX_DR-1:0] drData;
   logic              tdo;
   logic              tms;
   logic              tdi;
   logic [3:0]        tapState;
   logic [MAX_DR-1:0] capturedDr;
   logic              busy;
   logic              done;
   logic              err;

   jtag_scan_engine #(.MAX_IR_WIDTH(MAX_IR), .MAX_DR_WIDTH(MAX_DR)) dut (
      .clk(clk), .reset(reset), .start(start), .skipIr(skipIr), .resetTap(resetTap),
      .irWidth(irWidth), .drWidth(drWidth), .irData(irData), .drData(drData), .tdo(tdo),
      .tms(tms), .tdi(tdi), .tapState(tapState), .capturedDr(capturedDr),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [3:0] model_tap;
   bit         q_tms[$];
   bit         q_tdi[$];

   function automatic logic [3:0] tap_step(input logic [3:0] s, input bit m);
      case (s)
         4'd0:  return m ? 4'd0  : 4'd1;
         4'd1:  return m ? 4'd2  : 4'd1;
         4'd2:  return m ? 4'd3  : 4'd10;
         4'd3:  return m ? 4'd0  : 4'd4;
         4'd4:  return m ? 4'd6  : 4'd5;
         4'd5:  return m ? 4'd6  : 4'd5;
         4'd6:  return m ? 4'd9  : 4'd7;
         4'd7:  return m ? 4'd8  : 4'd7;
         4'd8:  return m ? 4'd9  : 4'd5;
         4'd9:  return m ? 4'd2  : 4'd1;
         4'd10: return m ? 4'd12 : 4'd11;
         4'd11: return m ? 4'd12 : 4'd11;
         4'd12: return m ? 4'd15 : 4'd13;
         4'd13: return m ? 4'd14 : 4'd13;
         4'd14: return m ? 4'd15 : 4'd11;
         default: return m ? 4'd2 : 4'd1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit m, input bit d);
      q_tms.push_back(m);
      q_tdi.push_back(d);
   endtask

   // Expected step list straight from the scan recipe.
   task automatic build(input bit skip, input int irw, input logic [MAX_IR-1:0] ird,
                        input int drw, input logic [MAX_DR-1:0] drd);
      q_tms.delete();
      q_tdi.delete();
      if (model_tap == 4'd0) push(1'b0, 1'b0);
      if (!skip) begin
         push(1, 0); push(1, 0); push(0, 0); push(0, 0);
         for (int b = 0; b < irw; b++) push(b == irw - 1, ird[b]);
         push(1, 0); push(1, 0);
         push(0, 0); push(0, 0);
      end else begin
         push(1, 0); push(0, 0); push(0, 0);
      end
      for (int b = 0; b < drw; b++) push(b == drw - 1, drd[b]);
      push(1, 0); push(0, 0);
   endtask

   // abort_at > 0 asserts reset during that shiftDr step instead of completing.
   task automatic run_scan(input bit skip, input int irw, input logic [MAX_IR-1:0] ird,
                           input int drw, input logic [MAX_DR-1:0] drd,
                           input logic [MAX_DR-1:0] tdov, input bit poke, input int abort_at);
      int          k;
      int          n;
      logic [63:0] mask;
      build(skip, irw, ird, drw, drd);
      n = q_tms.size();
      skipIr = skip; irWidth = irw[2:0]; irData = ird; drWidth = drw[5:0]; drData = drd;
      start = 1'b1;
      tick();
      start = 1'b0;
      skipIr = 1'($urandom); irWidth = 3'($urandom); drWidth = 6'($urandom);
      irData = 5'($urandom); drData = $urandom;
      k = 0;
      for (int i = 0; i < n; i++) begin
         check("busy_step", 64'(busy), 64'd1);
         check("tms_step", 64'(tms), 64'(q_tms[i]));
         check("tdi_step", 64'(tdi), 64'(q_tdi[i]));
         check("tap_step", 64'(tapState), 64'(model_tap));
         check("done_early", 64'(done), 64'd0);
         if (model_tap == 4'd11) begin
            tdo = tdov[k];
            k++;
         end else begin
            tdo = 1'($urandom);
         end
         start = (poke && i == 2);
         resetTap = (poke && i == 2);
         if (abort_at > 0 && model_tap == 4'd11 && k == abort_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            model_tap = 4'd0;
            check("abort_tap", 64'(tapState), 64'd0);
            check("abort_tms", 64'(tms), 64'd1);
            check("abort_tdi", 64'(tdi), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_cap", 64'(capturedDr), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            for (int j = 0; j < 3; j++) begin
               tick();
               check("abort_no_done", 64'(done), 64'd0);
               check("abort_idle_tap", 64'(tapState), 64'd0);
            end
            $display("scan aborted by reset at shiftDr step %0d", abort_at);
            return;
         end
         model_tap = tap_step(model_tap, q_tms[i]);
         tick();
      end
      start = 1'b0;
      resetTap = 1'b0;
      mask = (64'd1 << drw) - 64'd1;
      check("done_pulse", 64'(done), 64'd1);
      check("busy_end", 64'(busy), 64'd0);
      check("tap_end", 64'(tapState), 64'd1);
      check("tms_end", 64'(tms), 64'd0);
      check("captured", 64'(capturedDr), 64'(tdov) & mask);
      tick();
      check("done_once", 64'(done), 64'd0);
      $display("scan skip=%0d irw=%0d drw=%0d steps=%0d captured=%h", skip, irw, drw, n, capturedDr);
   endtask

   task automatic run_tap_reset(input bit with_start);
      resetTap = 1'b1;
      start = with_start;
      skipIr = 1'b0; irWidth = 3'd4; drWidth = 6'd8;
      tick();
      resetTap = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst_busy", 64'(busy), 64'd1);
         check("rst_tms", 64'(tms), 64'd1);
         check("rst_tap", 64'(tapState), 64'(model_tap));
         check("rst_done_early", 64'(done), 64'd0);
         model_tap = tap_step(model_tap, 1'b1);
         tick();
      end
      check("rst_done", 64'(done), 64'd1);
      check("rst_busy_end", 64'(busy), 64'd0);
      check("rst_tap_end", 64'(tapState), 64'd0);
      check("rst_tms_end", 64'(tms), 64'd1);
      tick();
      check("rst_done_once", 64'(done), 64'd0);
      check("rst_still_idle", 64'(busy), 64'd0);
      $display("tap reset with_start=%0d tapState=%0d", with_start, tapState);
   endtask

   task automatic run_err(input bit skip, input int irw, input int drw);
      logic hold;
      hold = (model_tap == 4'd0);
      skipIr = skip; irWidth = irw[2:0]; drWidth = drw[5:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      check("err_pulse", 64'(err), 64'd1);
      check("err_busy", 64'(busy), 64'd0);
      check("err_tms", 64'(tms), 64'(hold));
      check("err_tap", 64'(tapState), 64'(model_tap));
      tick();
      check("err_once", 64'(err), 64'd0);
      check("err_busy2", 64'(busy), 64'd0);
      check("err_tms2", 64'(tms), 64'(hold));
      $display("rejected skip=%0d irw=%0d drw=%0d err seen", skip, irw, drw);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; skipIr = 1'b0; resetTap = 1'b0;
      irWidth = '0; drWidth = '0; irData = '0; drData = '0; tdo = 1'b0;
      model_tap = 4'd0;
      repeat (3) tick();
      check("rst_tms_val", 64'(tms), 64'd1);
      check("rst_tdi_val", 64'(tdi), 64'd0);
      check("rst_tap_val", 64'(tapState), 64'd0);
      check("rst_busy_val", 64'(busy), 64'd0);
      check("rst_done_val", 64'(done), 64'd0);
      check("rst_err_val", 64'(err), 64'd0);
      check("rst_cap_val", 64'(capturedDr), 64'd0);
      reset = 1'b0;
      tick();
      check("post_rst_tms", 64'(tms), 64'd1);
      check("post_rst_tap", 64'(tapState), 64'd0);
      $display("reset values checked");

      run_scan(1'b0, 5, 5'b00110, 8, 32'h0000_00A5, 32'h0000_003C, 1'b0, 0);
      run_scan(1'b1, 0, 5'd0, 32, 32'hDEAD_BEEF, $urandom, 1'b0, 0);
      run_tap_reset(1'b0);
      run_scan(1'b0, 3, 5'b101, 5, 32'h15, 32'h0A, 1'b0, 0);

      run_err(1'b0, 6, 8);
      run_err(1'b0, 3, 0);
      run_err(1'b0, 0, 8);
      run_err(1'b1, 2, 33);

      run_scan(1'b0, 1, 5'b1, 1, 32'h1, 32'h1, 1'b1, 0);
      run_tap_reset(1'b1);

      for (int r = 0; r < 6; r++) begin
         run_scan(1'($urandom), $urandom_range(1, MAX_IR), 5'($urandom),
                  $urandom_range(1, MAX_DR), $urandom, $urandom, 1'($urandom), 0);
      end

      run_scan(1'b0, 4, 5'b1001, 12, 32'hABC, 32'hFFF, 1'b0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
